// File: rtl/branch_predictor_if.sv
// Lookup (IF stage) and update (EX stage) signals between the core and the branch predictor.
interface branch_predictor_if #(
    parameter int DWIDTH = 32
);
    logic              lk_hit;
    logic              lk_taken;
    logic [DWIDTH-1:0] lk_pc;
    logic [DWIDTH-1:0] lk_target;
    logic              upd_valid;
    logic              upd_uncond;
    logic              upd_taken;
    logic [DWIDTH-1:0] upd_pc;
    logic [DWIDTH-1:0] upd_target;

    modport master (
        output lk_pc,
        input  lk_hit, lk_taken, lk_target,
        output upd_valid, upd_pc, upd_uncond, upd_taken, upd_target
    );

    modport slave (
        input  lk_pc,
        output lk_hit, lk_taken, lk_target,
        input  upd_valid, upd_pc, upd_uncond, upd_taken, upd_target
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with saturating per-entry counters; same-cycle lookup, posedge update.
// Optional global-history index hash enabled by defining BP_GSHARE_EN.
module branch_predictor #(
    parameter int DWIDTH  = 32,
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 2
) (
    input logic               clk,
    input logic               rst,
    branch_predictor_if.slave bp
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = DWIDTH - IDX_W - 2;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_WNT = CNT_MAX >> 1;
    localparam logic [CNT_W-1:0] CNT_WT  = ~CNT_WNT;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] c);
        return (c == '0) ? c : c - CNT_W'(1);
    endfunction

    logic              valid  [ENTRIES];
    logic [CNT_W-1:0]  cnt    [ENTRIES];
    logic [TAG_W-1:0]  tag    [ENTRIES];
    logic [DWIDTH-1:0] target [ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [TAG_W-1:0] up_tag;

    assign lk_tag = bp.lk_pc[DWIDTH-1:IDX_W+2];
    assign up_tag = bp.upd_pc[DWIDTH-1:IDX_W+2];

`ifdef BP_GSHARE_EN
    logic [IDX_W-1:0] ghr;

    // Both paths hash with the history as it stands before this cycle's shift.
    assign lk_idx = bp.lk_pc[IDX_W+1:2] ^ ghr;
    assign up_idx = bp.upd_pc[IDX_W+1:2] ^ ghr;

    always_ff @(posedge clk) begin
        if (rst) begin
            ghr <= '0;
        end else if (bp.upd_valid && !bp.upd_uncond) begin
            ghr <= (ghr << 1) | IDX_W'(bp.upd_taken);
        end
    end
`else
    assign lk_idx = bp.lk_pc[IDX_W+1:2];
    assign up_idx = bp.upd_pc[IDX_W+1:2];
`endif

    logic unused_pc_bits;
    assign unused_pc_bits = ^{bp.lk_pc[1:0], bp.upd_pc[1:0]};

    // Lookup: purely combinational on lk_pc and registered state.
    always_comb begin
        bp.lk_hit    = valid[lk_idx] && (tag[lk_idx] == lk_tag);
        bp.lk_taken  = bp.lk_hit && cnt[lk_idx][CNT_W-1];
        bp.lk_target = bp.lk_taken ? target[lk_idx] : bp.lk_pc + DWIDTH'(4);
    end

    logic             up_hit;
    logic             eff_taken;
    logic             do_cnt;
    logic             do_alloc;
    logic             do_tgt;
    logic [CNT_W-1:0] nxt_cnt;

    assign up_hit    = valid[up_idx] && (tag[up_idx] == up_tag);
    assign eff_taken = bp.upd_uncond || bp.upd_taken;

    always_comb begin
        do_cnt   = 1'b0;
        do_alloc = 1'b0;
        do_tgt   = 1'b0;
        nxt_cnt  = cnt[up_idx];
        if (bp.upd_valid) begin
            if (up_hit) begin
                do_cnt = 1'b1;
                if (bp.upd_uncond) begin
                    nxt_cnt = CNT_MAX;
                    do_tgt  = 1'b1;
                end else if (bp.upd_taken) begin
                    nxt_cnt = sat_inc(cnt[up_idx]);
                    do_tgt  = 1'b1;
                end else begin
                    nxt_cnt = sat_dec(cnt[up_idx]);
                end
            end else if (eff_taken) begin
                // Allocation evicts whatever aliasing entry sits at this index.
                do_alloc = 1'b1;
                do_cnt   = 1'b1;
                do_tgt   = 1'b1;
                nxt_cnt  = bp.upd_uncond ? CNT_MAX : CNT_WT;
            end
        end
    end

    // Control state: valid bits and counters are reset; reset wins over an update.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid[i] <= 1'b0;
                cnt[i]   <= CNT_WNT;
            end
        end else begin
            if (do_alloc) valid[up_idx] <= 1'b1;
            if (do_cnt)   cnt[up_idx]   <= nxt_cnt;
        end
    end

    // Payload storage is never read while its entry is invalid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (do_alloc) tag[up_idx]    <= up_tag;
        if (do_tgt)   target[up_idx] <= bp.upd_target;
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (default build, ENTRIES = 16, CNT_W = 2).
module tb_branch_predictor;
    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    branch_predictor_if #(.DWIDTH(32)) bus ();

    branch_predictor #(.DWIDTH(32), .ENTRIES(16), .CNT_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic look(input string tag, input logic [31:0] pc,
                        input logic hit, input logic taken, input logic [31:0] tgt);
        bus.lk_pc = pc;
        #1;
        check({tag, ".hit"},    32'(bus.lk_hit),   32'(hit));
        check({tag, ".taken"},  32'(bus.lk_taken), 32'(taken));
        check({tag, ".target"}, bus.lk_target,     tgt);
    endtask

    task automatic upd(input logic [31:0] pc, input logic uncond, input logic taken,
                       input logic [31:0] tgt);
        bus.upd_valid  = 1'b1;
        bus.upd_pc     = pc;
        bus.upd_uncond = uncond;
        bus.upd_taken  = taken;
        bus.upd_target = tgt;
        @(posedge clk);
        #1;
        bus.upd_valid = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        bus.lk_pc      = 32'h0;
        bus.upd_valid  = 1'b0;
        bus.upd_pc     = 32'h0;
        bus.upd_uncond = 1'b0;
        bus.upd_taken  = 1'b0;
        bus.upd_target = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        look("reset", 32'h40, 1'b0, 1'b0, 32'h44);

        upd(32'h40, 1'b0, 1'b1, 32'h80);
        look("alloc", 32'h40, 1'b1, 1'b1, 32'h80);
        look("lowbits", 32'h41, 1'b1, 1'b1, 32'h80);

        upd(32'h40, 1'b0, 1'b0, 32'h0);
        look("nt1_01", 32'h40, 1'b1, 1'b0, 32'h44);
        upd(32'h40, 1'b0, 1'b0, 32'h0);
        look("nt2_00", 32'h40, 1'b1, 1'b0, 32'h44);
        upd(32'h40, 1'b0, 1'b1, 32'h80);
        look("t1_01", 32'h40, 1'b1, 1'b0, 32'h44);
        upd(32'h40, 1'b0, 1'b1, 32'h80);
        look("t2_10", 32'h40, 1'b1, 1'b1, 32'h80);
        upd(32'h40, 1'b0, 1'b1, 32'h80);
        upd(32'h40, 1'b0, 1'b1, 32'h90);
        look("sat_tgt", 32'h40, 1'b1, 1'b1, 32'h90);
        upd(32'h40, 1'b0, 1'b0, 32'h0);
        look("sat_11_10", 32'h40, 1'b1, 1'b1, 32'h90);

        upd(32'hC4, 1'b0, 1'b0, 32'h300);
        look("miss_nt", 32'hC4, 1'b0, 1'b0, 32'hC8);

        look("alias_pre", 32'h80, 1'b0, 1'b0, 32'h84);
        upd(32'h80, 1'b1, 1'b0, 32'h200);
        look("j_alloc", 32'h80, 1'b1, 1'b1, 32'h200);
        look("evicted", 32'h40, 1'b0, 1'b0, 32'h44);
        upd(32'h80, 1'b0, 1'b0, 32'h0);
        look("j_cnt11", 32'h80, 1'b1, 1'b1, 32'h200);

        upd(32'h40, 1'b0, 1'b1, 32'h80);
        upd(32'h40, 1'b0, 1'b0, 32'h0);
        look("coll_pre", 32'h40, 1'b1, 1'b0, 32'h44);
        bus.upd_valid  = 1'b1;
        bus.upd_pc     = 32'h40;
        bus.upd_uncond = 1'b0;
        bus.upd_taken  = 1'b1;
        bus.upd_target = 32'h80;
        look("coll_same", 32'h40, 1'b1, 1'b0, 32'h44);
        @(posedge clk);
        #1;
        bus.upd_valid = 1'b0;
        look("coll_next", 32'h40, 1'b1, 1'b1, 32'h80);

        rst            = 1'b1;
        bus.upd_valid  = 1'b1;
        bus.upd_pc     = 32'h40;
        bus.upd_uncond = 1'b0;
        bus.upd_taken  = 1'b1;
        bus.upd_target = 32'h100;
        @(posedge clk);
        #1;
        rst           = 1'b0;
        bus.upd_valid = 1'b0;
        look("rst_40", 32'h40, 1'b0, 1'b0, 32'h44);
        look("rst_80", 32'h80, 1'b0, 1'b0, 32'h84);

        upd(32'h40, 1'b0, 1'b1, 32'h80);
        upd(32'h40, 1'b0, 1'b0, 32'h0);
        look("rst_wnt", 32'h40, 1'b1, 1'b0, 32'h44);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
Parametrised dynamic branch predictor that lets the pipeline stop resolving every BEQ/J/JAL only in EX with a fixed flush. In IF it looks up the current pc and returns a predicted next-pc in the same cycle. The core updates it from EX with the resolved outcome and target. It combines a direct-mapped branch target buffer with saturating per-entry counters and an optional global-history index hash.

Parameters:
DWIDTH, 32, pc/target width
ENTRIES, 16, table entries; power of two, >= 2; IDX_W = log2(ENTRIES)
CNT_W, 2, saturating counter width, >= 1
TAG_W, DWIDTH-IDX_W-2 (derived, not overridable), tag = pc[DWIDTH-1:IDX_W+2]

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  synchronous active-high reset
lk_pc  in  DWIDTH  IF-stage pc to predict
lk_hit  out  1  valid entry with matching tag
lk_taken  out  1  lk_hit && counter MSB == 1
lk_target  out  DWIDTH  stored target if lk_taken, else lk_pc + 4
upd_valid  in  1  EX resolved a control instruction this cycle
upd_pc  in  DWIDTH  pc of the resolved instruction
upd_uncond  in  1  1 = J/JAL, 0 = BEQ
upd_taken  in  1  resolved direction; ignored when upd_uncond = 1, which is treated as taken
upd_target  in  DWIDTH  resolved target address

Behaviour:
- Reset: on the posedge with rst = 1, clear every valid bit, set every counter to weakly-not-taken (0b01..1 for CNT_W >= 2; 0 for CNT_W = 1), and zero the GHR. rst overrides any upd_valid in the same cycle.
- Lookup path is purely combinational on lk_pc and registered state (0-cycle latency). Outputs are never X after reset.
- Lookup index is pc[IDX_W+1:2] (pc bits [1:0] ignored).
- Update takes effect at the posedge. A lookup in the same cycle as an update to the same entry returns the pre-update contents; the new value is visible from the next cycle.
- Update rules at entry idx(upd_pc):
  - Hit, effective taken: counter +1 saturating at all-ones; target <= upd_target.
  - Hit, not taken: counter -1 saturating at 0; target unchanged; entry stays valid.
  - Miss (invalid or tag mismatch), effective taken: allocate. valid <= 1, tag <= upd_pc tag, target <= upd_target. Counter <= weakly-taken (MSB 1, rest 0); for upd_uncond, counter <= all-ones. This replaces any aliasing entry.
  - Miss, not taken: no change to the table.
  - upd_uncond hit: counter <= all-ones.
- JR must not be sent (upd_valid = 0 for JR); its target is data-dependent.
- At most one update per cycle; no backpressure; no ready signal.
- Mispredict detection and the flush decision stay in the core: it compares lk_taken/lk_target, carried down the pipe, against the EX outcome.

Optional Feature:
BP_GSHARE_EN.
- Defined: a GHR of IDX_W bits. On each update with upd_uncond = 0, GHR <= {GHR[IDX_W-2:0], upd_taken} (for IDX_W = 1, GHR <= upd_taken). The index for both lookup and update is pc[IDX_W+1:2] XOR GHR. The update uses the GHR value before its own shift. The tag check is unchanged.
- Undefined: no GHR is present, and the index is pc[IDX_W+1:2] only.

Test Plan:
- Defaults, after reset: lk_pc = 0x40 -> lk_hit = 0, lk_taken = 0, lk_target = 0x44.
- Allocate: update pc 0x40, BEQ taken, target 0x80. Next cycle lk_pc = 0x40 -> hit 1, taken 1, target 0x80.
- Hysteresis, continuing from the previous test: two not-taken updates give counter 10 -> 01 -> 00, and lk_taken = 0 after the first. Then three taken updates give 01, 10, 11, and lk_taken = 1 from the second. A fourth taken update leaves the counter at 11.
- Alias and uncond (ENTRIES = 16): with 0x40 allocated, lk_pc = 0x80 (same index 0, tag 2) -> hit 0. Then J update at 0x80, target 0x200 -> lk_pc 0x80 gives hit 1, taken 1, target 0x200, and lk_pc 0x40 gives hit 0.
- Same-cycle collision: entry 0x40 has counter 01. A taken update and lk_pc = 0x40 in the same cycle -> lk_taken = 0 that cycle, 1 the next.
- Reset mid-operation: rst = 1 together with a taken upd_valid at 0x40 -> next cycle lk_hit = 0 for every pc. With BP_GSHARE_EN, the GHR is 0, checked by index equality with the non-hashed case.
